cla_pipe_addsub: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshaking, the successor to the team's fixed 64-bit registered CLA. The carry chain is split into SEG_W-bit segments, one pipeline stage per segment, so WIDTH can grow without lengthening the critical path. It sits between operand-issue logic and result writeback, and accepts one operation per cycle when not back-pressured.

---
 rtl/cla_pipe_addsub.sv | 158 +++++++++++++++
 tb/tb_cla_pipe_addsub.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one SEG_W-bit segment resolved per stage,
// with skewed operand forwarding and a valid/ready handshake that stalls the whole pipe.
`timescale 1ns/1ps

module cla_pipe_addsub #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SEG_W = 16,
  parameter int unsigned OCC_W = $clog2(WIDTH / SEG_W + 2)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [OCC_W-1:0] occ
);

  localparam int unsigned NSEG = WIDTH / SEG_W;
  localparam int unsigned NGRP = SEG_W / 4;

  if ((WIDTH % SEG_W) != 0 || (SEG_W % 4) != 0 || WIDTH < 4) begin : g_param_check
    $error("cla_pipe_addsub: WIDTH must be >= 4 and a multiple of SEG_W; SEG_W a multiple of 4");
  end

  // Returns {carry into segment MSB, segment carry-out, segment sum}.
  function automatic logic [SEG_W+1:0] seg_add(input logic [SEG_W-1:0] a,
                                               input logic [SEG_W-1:0] b,
                                               input logic             ci);
    logic [SEG_W-1:0] g, p;
    logic [NGRP-1:0]  gg, gp;
    logic [NGRP:0]    gc;
    logic [SEG_W:0]   c;
    logic             acc, prod;
    g = a & b;
    p = a ^ b;
    for (int unsigned j = 0; j < NGRP; j++) begin
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = &p[4*j +: 4];
    end
    // Each group carry is a flat sum-of-products over lower groups and the segment carry-in.
    gc[0] = ci;
    for (int unsigned j = 0; j < NGRP; j++) begin
      acc  = 1'b0;
      prod = 1'b1;
      for (int unsigned i = 0; i <= j; i++) begin
        acc  = acc | (prod & gg[j-i]);
        prod = prod & gp[j-i];
      end
      gc[j+1] = acc | (prod & ci);
    end
    c = '0;
    for (int unsigned j = 0; j < NGRP; j++) begin
      c[4*j] = gc[j];
      for (int unsigned t = 0; t < 3; t++) begin
        c[4*j+t+1] = g[4*j+t] | (p[4*j+t] & c[4*j+t]);
      end
    end
    c[SEG_W] = gc[NGRP];
    return {c[SEG_W-1], c[SEG_W], p ^ c[SEG_W-1:0]};
  endfunction

  logic [NSEG-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [NSEG-1:0]            c_q, c_d;
  logic [NSEG:1][WIDTH-1:0]   s_q, s_d;
  logic [NSEG:0]              v_q, v_d;
  logic [NSEG:1][SEG_W+1:0]   seg_r;
  logic                       cout_q, cout_d, ovf_q, ovf_d;
  logic [OCC_W-1:0]           occ_q, occ_d;
  logic                       en, accept, consume;

  assign en      = !v_q[NSEG] | out_ready;
  assign accept  = in_valid & en;
  assign consume = v_q[NSEG] & out_ready;

  always_comb begin
    a_d    = '0;
    b_d    = '0;
    c_d    = '0;
    s_d    = '0;
    v_d    = '0;
    seg_r  = '0;
    cout_d = 1'b0;
    ovf_d  = 1'b0;
    occ_d  = occ_q;

    a_d[0] = op_a;
    b_d[0] = sub ? ~op_b : op_b;
    c_d[0] = sub | cin;
    v_d[0] = accept;

    for (int unsigned k = 1; k <= NSEG; k++) begin
      seg_r[k] = seg_add(a_q[k-1][(k-1)*SEG_W +: SEG_W],
                         b_q[k-1][(k-1)*SEG_W +: SEG_W], c_q[k-1]);
      v_d[k]   = v_q[k-1];
    end
    // Finished lower sum bits ride along; stage 1 starts from an empty sum.
    for (int unsigned k = 2; k <= NSEG; k++) begin
      s_d[k] = s_q[k-1];
    end
    for (int unsigned k = 1; k <= NSEG; k++) begin
      s_d[k][(k-1)*SEG_W +: SEG_W] = seg_r[k][SEG_W-1:0];
    end
    for (int unsigned k = 1; k < NSEG; k++) begin
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
      c_d[k] = seg_r[k][SEG_W];
    end
    cout_d = seg_r[NSEG][SEG_W];
    ovf_d  = seg_r[NSEG][SEG_W] ^ seg_r[NSEG][SEG_W+1];

    if (accept && !consume) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!accept && consume) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      s_q    <= '0;
      v_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      occ_q  <= '0;
    end else begin
      occ_q <= occ_d;
      if (en) begin
        a_q    <= a_d;
        b_q    <= b_d;
        c_q    <= c_d;
        s_q    <= s_d;
        v_q    <= v_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign in_ready  = en;
  assign out_valid = v_q[NSEG];
  assign sum       = s_q[NSEG];
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign occ       = occ_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: directed vector table, back-pressure and reset sequences on a
// 64/16 instance, plus randomized streams on three geometries against a wide-arithmetic model.
`timescale 1ns/1ps

module tb_cla_pipe_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int sw_fin  = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Returns {ovf, cout, sum}: sum masked to w bits, overflow from the sign rule.
  function automatic logic [129:0] ref_add(input int unsigned w, input logic [127:0] a,
                                           input logic [127:0] b, input logic ci,
                                           input logic sb);
    logic [127:0] mask, am, be;
    logic [128:0] full;
    logic         ov;
    mask = (w == 128) ? '1 : ((128'd1 << w) - 128'd1);
    am   = a & mask;
    be   = (sb ? ~b : b) & mask;
    full = {1'b0, am} + {1'b0, be} + 129'(sb | ci);
    ov   = (am[w-1] == be[w-1]) && (full[w-1] != am[w-1]);
    return {ov, full[w], full[127:0] & mask};
  endfunction

  // Main 64/16 instance for directed work.
  logic        m_rst_n, m_in_valid, m_in_ready, m_cin, m_sub;
  logic        m_out_valid, m_out_ready, m_cout, m_ovf;
  logic [63:0] m_op_a, m_op_b, m_sum;
  logic [2:0]  m_occ;

  cla_pipe_addsub #(.WIDTH(64), .SEG_W(16), .OCC_W(3)) u_dut (
    .clock(clk), .reset(m_rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .op_a(m_op_a), .op_b(m_op_b), .cin(m_cin), .sub(m_sub),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .sum(m_sum),
    .cout(m_cout), .ovf(m_ovf), .occ(m_occ)
  );

  typedef struct {
    logic [63:0] a, b;
    logic        ci, sb;
    logic [63:0] s;
    logic        co, ov;
  } vec_t;

  logic [129:0] mq[$];
  int           m_got;

  // Called at posedge+1; drives one cycle and scores it.
  task automatic m_step(input logic iv, input logic [63:0] a, input logic [63:0] b,
                        input logic ci, input logic sb, input logic rdy, output logic acc);
    logic [129:0] r;
    m_in_valid = iv; m_op_a = a; m_op_b = b; m_cin = ci; m_sub = sb; m_out_ready = rdy;
    #1;
    chk("m_in_ready", m_in_ready, !m_out_valid || rdy);
    chk("m_occ", m_occ, mq.size());
    if (m_out_valid) begin
      chk("m_valid_with_work", mq.size() > 0, 1'b1);
      if (mq.size() > 0) begin
        r = mq[0];
        chk("m_sum", m_sum, r[63:0]);
        chk("m_cout", m_cout, r[128]);
        chk("m_ovf", m_ovf, r[129]);
        if (rdy) begin
          void'(mq.pop_front());
          m_got++;
        end
      end
    end
    acc = iv && m_in_ready;
    if (acc) mq.push_back(ref_add(64, {64'd0, a}, {64'd0, b}, ci, sb));
    @(posedge clk); #1;
  endtask

  // Called at posedge+1; one operation alone through an idle pipe.
  task automatic run_vec(input string nm, input logic [63:0] a, input logic [63:0] b,
                         input logic ci, input logic sb, input logic [63:0] es,
                         input logic eco, input logic eov);
    int lat;
    m_in_valid = 1'b1; m_op_a = a; m_op_b = b; m_cin = ci; m_sub = sb; m_out_ready = 1'b1;
    #1;
    chk({nm, "_in_ready"}, m_in_ready, 1'b1);
    @(posedge clk); #1;
    m_in_valid = 1'b0;
    lat = 0;
    while (!m_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, lat, 4);
    chk({nm, "_sum"}, m_sum, es);
    chk({nm, "_cout"}, m_cout, eco);
    chk({nm, "_ovf"}, m_ovf, eov);
    @(posedge clk); #1;
  endtask

  // Randomized streams on three geometries.
  logic rst_n;
  localparam int unsigned NOPS = 10000;

  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int unsigned W  = (g == 0) ? 32 : (g == 1) ? 128 : 64;
    localparam int unsigned S  = (g == 0) ? 32 : (g == 1) ? 8 : 16;
    localparam int unsigned NS = W / S;
    localparam int unsigned OW = $clog2(NS + 2);

    logic          iv, ir, ovl, rdy, ci, sb, co, of;
    logic [W-1:0]  a, b, s;
    logic [OW-1:0] oc;

    cla_pipe_addsub #(.WIDTH(W), .SEG_W(S), .OCC_W(OW)) u_sw (
      .clock(clk), .reset(rst_n), .in_valid(iv), .in_ready(ir),
      .op_a(a), .op_b(b), .cin(ci), .sub(sb),
      .out_valid(ovl), .out_ready(rdy), .sum(s),
      .cout(co), .ovf(of), .occ(oc)
    );

    initial begin
      logic [129:0] eq[$];
      int unsigned  aq[$];
      logic [127:0] ra, rb;
      logic [129:0] r;
      logic         exp_ov;
      int unsigned  sent;
      iv = 1'b0; rdy = 1'b0; ci = 1'b0; sb = 1'b0; a = '0; b = '0;
      sent = 0;
      wait (rst_n === 1'b1);
      @(posedge clk); #1;
      for (int cyc = 0; cyc < 40000 && (sent < NOPS || eq.size() > 0); cyc++) begin
        ra = {$urandom, $urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom, $urandom};
        if ($urandom_range(0, 7) == 0) rb = ~ra;
        a   = ra[W-1:0];
        b   = rb[W-1:0];
        ci  = 1'($urandom);
        sb  = 1'($urandom);
        iv  = (sent < NOPS) && ($urandom_range(0, 3) != 0);
        rdy = ($urandom_range(0, 3) != 0);
        #1;
        exp_ov = 1'b0;
        if (eq.size() > 0) exp_ov = (aq[0] == NS);
        chk($sformatf("sw%0d_out_valid", W), ovl, exp_ov);
        chk($sformatf("sw%0d_in_ready", W), ir, !exp_ov || rdy);
        chk($sformatf("sw%0d_occ", W), oc, eq.size());
        if (exp_ov && rdy) begin
          r = eq.pop_front();
          void'(aq.pop_front());
          chk($sformatf("sw%0d_sum", W), s, r[127:0]);
          chk($sformatf("sw%0d_cout", W), co, r[128]);
          chk($sformatf("sw%0d_ovf", W), of, r[129]);
        end
        if (!exp_ov || rdy) begin
          foreach (aq[i]) aq[i] = aq[i] + 1;
          if (iv) begin
            eq.push_back(ref_add(W, ra, rb, ci, sb));
            aq.push_back(0);
            sent++;
          end
        end
        @(posedge clk); #1;
      end
      iv = 1'b0;
      chk($sformatf("sw%0d_drained", W), eq.size(), 0);
      sw_fin++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t         tbl[12];
    logic [63:0]  pa, pb, held;
    logic         pc, ps, acc;
    logic [129:0] r;
    int           issued, stall;

    tbl[0]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0};
    tbl[1]  = '{64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    tbl[2]  = '{64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0};
    tbl[3]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    tbl[4]  = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    tbl[5]  = '{64'd0, 64'd0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0};
    tbl[6]  = '{64'd10, 64'd3, 1'b1, 1'b1, 64'd7, 1'b1, 1'b0};
    tbl[7]  = '{64'd0, 64'd0, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0};
    tbl[8]  = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    tbl[9]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1};
    tbl[10] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0};
    tbl[11] = '{64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0001_0000_0000_0000, 1'b0, 1'b0};

    m_rst_n = 1'b0; rst_n = 1'b0;
    m_in_valid = 1'b0; m_out_ready = 1'b0; m_op_a = '0; m_op_b = '0; m_cin = 1'b0; m_sub = 1'b0;
    m_got = 0;
    #3;
    chk("rst_out_valid", m_out_valid, 1'b0);
    chk("rst_sum", m_sum, 64'd0);
    chk("rst_cout", m_cout, 1'b0);
    chk("rst_ovf", m_ovf, 1'b0);
    chk("rst_occ", m_occ, 3'd0);
    #19;
    m_rst_n = 1'b1; rst_n = 1'b1;
    #1;
    chk("rst_in_ready", m_in_ready, 1'b1);
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].sb,
              tbl[i].s, tbl[i].co, tbl[i].ov);
    end

    // Back-pressure: fill the pipe against a stalled consumer, then drain in order.
    mq.delete();
    m_got = 0; issued = 0; stall = 0; held = '0;
    pa = {$urandom, $urandom}; pb = {$urandom, $urandom}; pc = 1'($urandom); ps = 1'($urandom);
    for (int cyc = 0; cyc < 100 && m_got < 10; cyc++) begin
      if (m_out_valid && stall < 6) begin
        chk("bp_occ_full", m_occ, 3'd5);
        if (stall == 0) held = m_sum;
        else chk("bp_sum_hold", m_sum, held);
        stall++;
      end
      m_step(issued < 10, pa, pb, pc, ps, stall >= 6, acc);
      if (acc) begin
        issued++;
        pa = {$urandom, $urandom}; pb = {$urandom, $urandom};
        pc = 1'($urandom); ps = 1'($urandom);
      end
    end
    chk("bp_results", m_got, 10);
    chk("bp_stall_cycles", stall, 6);

    // Reset mid-flight: three operations in flight are discarded.
    mq.delete();
    for (int i = 0; i < 3; i++) begin
      m_step(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 1'($urandom),
             1'b1, acc);
    end
    chk("midrst_pre_occ", m_occ, 3'd3);
    m_in_valid = 1'b0;
    m_rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", m_out_valid, 1'b0);
    chk("midrst_occ", m_occ, 3'd0);
    chk("midrst_sum", m_sum, 64'd0);
    mq.delete();
    #9;
    m_rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", m_in_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_ghost", m_out_valid, 1'b0);
    end
    pa = {$urandom, $urandom}; pb = {$urandom, $urandom};
    r = ref_add(64, {64'd0, pa}, {64'd0, pb}, 1'b0, 1'b1);
    run_vec("midrst_after", pa, pb, 1'b0, 1'b1, r[63:0], r[128], r[129]);

    wait (sw_fin == 3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
